// File: rtl/mix32.sv
// mix32: time-multiplexed stimulus generator serialising 32 slot values onto one bus, aligned to a slot counter and pipeline stage.
// Latency: a write reaches the shadow bank next cycle and appears on mixed in the frame after the next boundary following a commit.
// Backpressure: none; the write port and the commit request are accepted every cycle.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data shadow-bank write port (one slot per cycle)
//   commit                request shadow -> active copy at the next frame boundary
//   cnt                   free-running 5-bit slot counter
//   mixed                 active[idx(cnt)], registered
//   frame_start           idx(cnt) == 0, registered
//   pending               commit requested but not yet applied
//   commit_ack            one-cycle pulse in the first cycle showing the new bank
module mix32 #(
  parameter int          width = 10,
  parameter logic [4:0]  stg   = 5'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [4:0]       wr_addr,
  input  logic [width-1:0] wr_data,
  input  logic             commit,
  output logic [4:0]       cnt,
  output logic [width-1:0] mixed,
  output logic             frame_start,
  output logic             pending,
  output logic             commit_ack
);

  logic [4:0]       cnt_q, cnt_d;
  logic [width-1:0] mixed_q, mixed_d;
  logic             frame_start_q, frame_start_d;
  logic             pending_q, pending_d;
  logic             commit_ack_q, commit_ack_d;
  logic [width-1:0] shadow_q [32];
  logic [width-1:0] active_q [32];

  logic             boundary;
  logic             do_copy;
  logic [4:0]       slot_d;
  logic [width-1:0] shadow_fwd;

  // Slot shown for counter value c: (c + 33 - stg) mod 32, i.e. c + 1 - stg in 5-bit arithmetic.
  function automatic logic [4:0] idx(input logic [4:0] c);
    return c + 5'd1 - stg;
  endfunction

  always_comb begin
    cnt_d         = cnt_q + 5'd1;
    boundary      = (idx(cnt_q) == 5'd31);
    do_copy       = boundary && pending_q;
    // A commit arriving in the boundary cycle with nothing pending waits a full frame;
    // one arriving while pending merges into the copy that is about to happen.
    pending_d     = !do_copy && (pending_q || commit);
    commit_ack_d  = do_copy;
    slot_d        = idx(cnt_d);
    frame_start_d = (slot_d == 5'd0);
    // The bus is registered, so look up the slot for the next counter value in the
    // bank as it will be after this edge, including a same-cycle write on a copy.
    shadow_fwd    = (wr_en && (wr_addr == slot_d)) ? wr_data : shadow_q[slot_d];
    mixed_d       = do_copy ? shadow_fwd : active_q[slot_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= 5'd0;
      mixed_q       <= '0;
      frame_start_q <= (idx(5'd0) == 5'd0);
      pending_q     <= 1'b0;
      commit_ack_q  <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      mixed_q       <= mixed_d;
      frame_start_q <= frame_start_d;
      pending_q     <= pending_d;
      commit_ack_q  <= commit_ack_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (wr_en && (wr_addr == 5'(i))) begin
          shadow_q[i] <= wr_data;
        end
        // Copy takes the post-write shadow value so a boundary-cycle write is included.
        if (do_copy) begin
          active_q[i] <= (wr_en && (wr_addr == 5'(i))) ? wr_data : shadow_q[i];
        end
      end
    end
  end

  assign cnt         = cnt_q;
  assign mixed       = mixed_q;
  assign frame_start = frame_start_q;
  assign pending     = pending_q;
  assign commit_ack  = commit_ack_q;

endmodule

// File: doc/mix32.md
# mix32

Time-multiplexing stimulus generator for 32-slot pipelined signals: holds one value per slot (octal slots 00–37) and serialises them onto a single bus aligned to the slot counter and a given pipeline stage. It is the inverse of the slot demultiplexer used in verification: a `mixed` bus from this block, fed with the same `cnt` and `stg` into the demultiplexer, reproduces the 32 loaded values. Values are loaded into a shadow bank through a write port and committed atomically at a frame boundary, so each frame on the bus is self-consistent.

## Interface
- `width`, default 10: slot data width.
- `stg`, default 5'd0: pipeline stage of the generated signal (`xx_VIII` → 8). Slot index for counter value c is idx(c) = (c + 33 − stg) mod 32.

- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `wr_en`  in  1: write strobe, one shadow slot per cycle.
- `wr_addr`  in  5: slot number (octal 00–37) to write.
- `wr_data`  in  width: value for that slot.
- `commit`  in  1: request shadow → active copy at next frame boundary.
- `cnt`  out  5: free-running slot counter.
- `mixed`  out  width: active[idx(cnt)].
- `frame_start`  out  1: high when idx(cnt) == 0.
- `pending`  out  1: commit requested, not yet applied.
- `commit_ack`  out  1: one-cycle pulse, copy has taken effect.

## Operation
- Two banks of 32×width registers: shadow (write port target), active (drives `mixed`).
- `cnt` increments by 1 every cycle, wraps 31 → 0.
- `mixed`, `frame_start` registered; computed from next `cnt` so that in every cycle `mixed` == active[idx(cnt)] and `frame_start` == (idx(cnt)==0) for the `cnt` shown that same cycle.
- Write: `wr_en`=1 at edge → shadow[`wr_addr`] ← `wr_data`. Active never written directly.
- Commit: `commit`=1 at edge sets `pending`. Boundary cycle B = cycle where idx(cnt) == 31 (last slot of frame). At the edge ending B with `pending`=1: active ← shadow, `pending` ← 0, `commit_ack` ← 1 for one cycle. First cycle after B (`frame_start`=1) shows new active[0].
- Write forwarding: a write in cycle B is included in the copy (copy uses post-write shadow value).
- `commit` in cycle B while `pending`=0: sets `pending`, applied at the next B (32 cycles later); not the current one.
- `commit` while `pending`=1 (incl. cycle B): merged, single ack. In cycle B with `pending`=1, `commit`=1: current copy executes; `pending` ends 0.
- Writes after a commit request but before B are included in that copy.
- No backpressure; write port always accepts.

## Timing
- Reset (edge with `rst`=1): `cnt`=0, both banks all 0, `mixed`=0, `pending`=0, `commit_ack`=0, `frame_start`=(idx(0)==0), i.e. 1 only when stg==1. `rst` overrides all inputs in that cycle; a pending commit is discarded.
- First cycle after reset release: `cnt`=0, idx = (33 − stg) mod 32; stg=0 → slot 01.
- Latency write → bus: write lands in shadow next cycle; visible on `mixed` only after commit, in the frame following the next B.
- `commit_ack` high in the same cycle as `frame_start` of the first frame using new data.
- Frame period: exactly 32 cycles; `frame_start` period 32.

## Test plan
- Reset, stg=0: hold `rst` 3 cycles → `cnt`=0, `mixed`=0, `pending`=0, `commit_ack`=0; next cycles `cnt`=1,2,…; `frame_start` first high at `cnt`=31.
- stg=0: write slot k ← 0x100+k for k=0..31, commit → on first frame after B, `mixed` at `cnt`=31,0,1,…,30 equals 0x100,0x101,…,0x11F; `commit_ack` single pulse with `frame_start`.
- Round trip stg=5: load slot k ← 3k+7, commit, connect `mixed`/`cnt` to the demultiplexer with stg=5 → after one full frame all 32 slot outputs equal 3k+7.
- Atomicity: active all 0x055; write new values and commit mid-frame; further writes before B → whole next frame shows new values incl. late writes, current frame unchanged 0x055.
- Boundary: write slot 03 ← 0x2AA in cycle B with `pending`=1 → next frame slot 03 = 0x2AA; `commit` first asserted in cycle B with `pending`=0 → `pending` stays 1 for 32 cycles, ack on following boundary; repeated commits → one ack.
- Reset mid-operation: `pending`=1, `rst` pulsed before B → `pending`=0, no `commit_ack`, banks and `mixed` 0, `cnt` restarts at 0.
